// File: rtl/riskow_pkg.sv
`default_nettype none
// ---- riskow_pkg : shared fetch-stage types and constants ------------------
// ---- rev 1.0 ----------------------------------------------------------------
package riskow_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_e;

  // Entry layout at the default 32-bit core widths; the FIFO stores it as a flat vector.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---- fetch_fifo : show-ahead FIFO with synchronous flush ------------------
// ---- rev 1.0 ----------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  // A pop frees the slot in the same edge, so a push at full is legal alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---- fetch_unit : PC, bus request/ack handshake and prefetch queue --------
// ---- rev 1.0 ----------------------------------------------------------------
module fetch_unit
  import riskow_pkg::*;
#(
  parameter int                    XLEN         = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  busRequest,
  output logic [ADDR_WIDTH-1:0] busAddress,
  input  logic                  busAck,
  input  logic [XLEN-1:0]       busDataIn,
  output logic                  insValid,
  output logic [XLEN-1:0]       insData,
  output logic [ADDR_WIDTH-1:0] insPc,
  input  logic                  insTake,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc
);

  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   c_lastSlot = CW'(DEPTH - 1);

  fetch_state_e              r_state;
  logic [ADDR_WIDTH-1:0]     r_fetchPc;
  logic                      r_busReq;
  logic [ADDR_WIDTH-1:0]     r_busAddr;

  logic [ADDR_WIDTH-1:0]     w_redirPc;
  logic [ADDR_WIDTH-1:0]     w_pcNext;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_stayFetch;
  logic [CW-1:0]             w_count;
  logic                      w_full;
  logic                      w_empty;
  logic [ADDR_WIDTH+XLEN-1:0] w_head;
  logic                      w_unused;

  assign w_redirPc = {redirectPc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused  = ^redirectPc[1:0];
  assign w_pcNext  = r_fetchPc + ADDR_WIDTH'(INSTR_BYTES);

  assign w_pop  = insTake && !w_empty && !redirectValid;
  assign w_push = (r_state == FETCH_REQ) && busAck && !redirectValid;
  // After this push the queue still has a free slot, so the next request is safe.
  assign w_stayFetch = w_pop || (w_count < c_lastSlot);

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (redirectValid),
    .i_push  (w_push),
    .i_data  ({r_fetchPc, busDataIn}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign insValid   = !w_empty;
  assign insPc      = w_head[ADDR_WIDTH+XLEN-1:XLEN];
  assign insData    = w_head[XLEN-1:0];
  assign busRequest = r_busReq;
  assign busAddress = r_busAddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH_IDLE;
      r_fetchPc <= RESET_VECTOR;
      r_busReq  <= 1'b0;
      r_busAddr <= RESET_VECTOR;
    end else if (redirectValid) begin
      r_fetchPc <= w_redirPc;
      if (r_state == FETCH_IDLE || busAck) begin
        r_state   <= FETCH_REQ;
        r_busReq  <= 1'b1;
        r_busAddr <= w_redirPc;
      end else begin
        // Unacked request must stay on the bus; its data is dropped later.
        r_state <= FETCH_FLUSH;
      end
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (!w_full) begin
            r_state   <= FETCH_REQ;
            r_busReq  <= 1'b1;
            r_busAddr <= r_fetchPc;
          end
        end
        FETCH_REQ: begin
          if (busAck) begin
            r_fetchPc <= w_pcNext;
            r_busAddr <= w_pcNext;
            if (!w_stayFetch) begin
              r_state  <= FETCH_IDLE;
              r_busReq <= 1'b0;
            end
          end
        end
        FETCH_FLUSH: begin
          if (busAck) begin
            r_state   <= FETCH_REQ;
            r_busAddr <= r_fetchPc;
          end
        end
        default: begin
          r_state  <= FETCH_IDLE;
          r_busReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---- tb_fetch_unit : randomized scoreboard bench for fetch_unit -----------
// ---- rev 1.0 ----------------------------------------------------------------
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busRequest;
  logic [31:0] busAddress;
  logic        busAck;
  logic [31:0] busDataIn;
  logic        insValid;
  logic [31:0] insData;
  logic [31:0] insPc;
  logic        insTake;
  logic        redirectValid;
  logic [31:0] redirectPc;

  fetch_unit #(
    .XLEN         (32),
    .ADDR_WIDTH   (32),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .busRequest    (busRequest),
    .busAddress    (busAddress),
    .busAck        (busAck),
    .busDataIn     (busDataIn),
    .insValid      (insValid),
    .insData       (insData),
    .insPc         (insPc),
    .insTake       (insTake),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_pc;
  bit          stale;
  bit          pop_pend;
  bit          hold_exp;
  logic [31:0] hold_addr;
  bit          mon_en;
  int          n_checks;
  int          n_fail;
  int          n_push;
  int          take_pct, redir_pct, lat_min, lat_max, lat, lat_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the decoder must see the in-order stream of acked,
  // non-stale fetches starting at the latest redirect target.
  task automatic model();
    bit take_eff;
    take_eff  = insTake && (sb.size() > 0) && !redirectValid;
    hold_exp  = busRequest && !busAck;
    hold_addr = busAddress;
    if (redirectValid) begin
      sb.delete();
      exp_pc   = {redirectPc[31:2], 2'b00};
      stale    = busRequest && !busAck;
      pop_pend = 1'b0;
    end else begin
      if (busRequest && busAck) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          chk("busAddress", 64'(busAddress), 64'(exp_pc));
          chk("slotReserved", 64'(sb.size() < DEPTH), 64'(1));
          sb.push_back('{pc: exp_pc, data: busDataIn});
          exp_pc += 32'd4;
          n_push++;
        end
      end
      pop_pend = take_eff;
    end
  endtask

  // ack_ctl: 0 random latency, 1 force ack, 2 force no ack
  task automatic step(input bit force_r = 1'b0, input logic [31:0] fpc = '0,
                      input int ack_ctl = 0);
    @(negedge clk);
    redirectValid = force_r || ($urandom_range(99) < redir_pct);
    if (force_r) redirectPc = fpc;
    else if ($urandom_range(3) == 0) redirectPc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else redirectPc = $urandom;
    insTake   = ($urandom_range(99) < take_pct);
    busDataIn = $urandom;
    if (busRequest) begin
      if (ack_ctl == 1) busAck = 1'b1;
      else if (ack_ctl == 2) busAck = 1'b0;
      else busAck = (lat_cnt >= lat);
      if (busAck) begin
        lat_cnt = 0;
        lat     = $urandom_range(lat_max, lat_min);
      end else begin
        lat_cnt++;
      end
    end else begin
      busAck = 1'($urandom_range(1));
    end
    model();
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    lat     = $urandom_range(hi, lo);
    lat_cnt = 0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !busRequest; i++) step();
    chk("reqTimeout", 64'(busRequest), 64'(1));
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (pop_pend) begin
        void'(sb.pop_front());
        pop_pend = 1'b0;
      end
      chk("insValid", 64'(insValid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("insPc", 64'(insPc), 64'(sb[0].pc));
        chk("insData", 64'(insData), 64'(sb[0].data));
      end
      if (hold_exp) begin
        chk("busHold", {31'd0, busRequest, busAddress}, {31'd0, 1'b1, hold_addr});
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    exp_pc   = 32'h0;
    stale    = 1'b0;
    pop_pend = 1'b0;
    hold_exp = 1'b0;
    lat_cnt  = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busRequest"}, 64'(busRequest), 64'(0));
    chk({tag, "_busAddress"}, 64'(busAddress), 64'(0));
    chk({tag, "_insValid"}, 64'(insValid), 64'(0));
    chk({tag, "_insData"}, 64'(insData), 64'(0));
    chk({tag, "_insPc"}, 64'(insPc), 64'(0));
  endtask

  initial begin
    logic [31:0] old_addr;
    n_checks = 0; n_fail = 0; n_push = 0; mon_en = 1'b0;
    reset = 1'b0; busAck = 1'b0; busDataIn = '0; insTake = 1'b0;
    redirectValid = 1'b0; redirectPc = '0;
    take_pct = 0; redir_pct = 0;
    set_lat(0, 0);
    model_reset();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Zero-wait fill with no consumption.
    step();
    chk("firstReqAfterReset", 64'(busRequest), 64'(1));
    repeat (5) step();
    chk("idleWhenFull", 64'(busRequest), 64'(0));
    chk("fullCount", 64'(sb.size()), 64'(4));
    chk("headPc", 64'(insPc), 64'(0));

    // Fixed three-cycle wait states with consumption.
    set_lat(3, 3);
    take_pct = 50;
    repeat (60) step();

    // Redirect against an unacked request.
    set_lat(5, 5);
    wait_req();
    old_addr = busAddress;
    step(1'b1, 32'h103, 2);
    step(1'b0, '0, 2);
    chk("flushHoldsOld", 64'(busAddress), 64'(old_addr));
    repeat (20) step();

    // Redirect coinciding with an ack.
    set_lat(0, 0);
    wait_req();
    step(1'b1, 32'h200, 1);
    step();
    chk("redirOnAckAddr", 64'(busAddress), 64'(32'h200));
    repeat (10) step();

    // Full queue drained while refetching back-to-back.
    take_pct = 100;
    repeat (20) step();

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 0);
    repeat (8) step();
    chk("wrapProgress", 64'(exp_pc < 32'h100), 64'(1));

    // Asynchronous reset in the middle of a stalled request.
    set_lat(8, 8);
    wait_req();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk_reset_outputs("midReset");
    model_reset();
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    set_lat(0, 0);
    take_pct = 0;
    step();
    chk("restartAddr", 64'(busAddress), 64'(0));

    // Random mix.
    n_push = 0;
    set_lat(0, 4);
    take_pct  = 60;
    redir_pct = 5;
    repeat (2000) step();
    chk("randomProgress", 64'(n_push > 100), 64'(1));

    redir_pct = 0;
    take_pct  = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
